// File: rtl/highway_controller_pkg.sv
// highway_controller_pkg: lamp codes, state encoding and default timings shared by the road controllers
package highway_controller_pkg;
  localparam logic [2:0] GREEN = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED = 3'b001;
  typedef enum logic [2:0] {
    GREEN_H = GREEN,
    YELLOW_H = YELLOW,
    RED_H = RED
  } state_e;
  localparam int LONG_DEFAULT = 30;
  localparam int YELLOW_DEFAULT = 4;
  localparam int RED_MAX_DEFAULT = 64;
  localparam int CNT_W_DEFAULT = 8;
endpackage

// File: rtl/light_timer.sv
// light_timer: reloadable down-counter that parks at zero and pulses start_t the cycle after each reload
module light_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done,
  output logic             start_t
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic start_q;
  assign done = cnt_q == '0;
  assign start_t = start_q;
  assign cnt_d = load ? value : cnt_q - CNT_W'(!done);
  // count register; value is already the terminal count (requested cycles minus one)
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= RST_VAL;
      start_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      start_q <= load;
    end
endmodule

// File: rtl/highway_controller.sv
// highway_controller: highway lamp FSM with sensor synchronizer and red watchdog; define CAR_DEBOUNCE_EN for a 3-sample car filter
module highway_controller
  import highway_controller_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_DEFAULT,
  parameter int YELLOW_CYCLES = YELLOW_DEFAULT,
  parameter int RED_MAX_CYCLES = RED_MAX_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       enable_h,
  output logic       enable_r,
  output logic [2:0] light_h,
  output logic       start_t,
  output logic       fault
);
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_T = CNT_W'(RED_MAX_CYCLES - 1);
  state_e state_q, state_d;
  logic [1:0] sync_q;
  logic car_q, init_q, enable_r_q, fault_q, fault_d, load, done;
  logic [CNT_W-1:0] load_val;
  // two-flop synchronizer for the asynchronous sensor
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[0], car};
`ifdef CAR_DEBOUNCE_EN
  logic [1:0] hist_q;
  logic deb_q;
  // adopt a new sensor level only once three consecutive synchronized samples agree
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hist_q <= '0;
      deb_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      deb_q <= (&{sync_q[1], hist_q} | ~|{sync_q[1], hist_q}) ? sync_q[1] : deb_q;
    end
  assign car_q = deb_q;
`else
  assign car_q = sync_q[1];
`endif
  // next state, watchdog flag and timer reload on every state entry
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      GREEN_H: state_d = (done && car_q) ? YELLOW_H : GREEN_H;
      YELLOW_H: state_d = done ? RED_H : YELLOW_H;
      RED_H: begin
        state_d = (enable_h || done) ? GREEN_H : RED_H;
        fault_d = fault_q | (done & ~enable_h);
      end
      default: state_d = GREEN_H;
    endcase
    load = init_q | (state_d != state_q);
    load_val = (state_d == GREEN_H) ? LONG_T : (state_d == YELLOW_H) ? YELLOW_T : RED_T;
  end
  // state register doubles as the lamp register; init_q forces a full green reload after reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= GREEN_H;
      init_q <= 1'b1;
      enable_r_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q <= 1'b0;
      enable_r_q <= (state_d == RED_H) && (state_q != RED_H);
      fault_q <= fault_d;
    end
  assign light_h = state_q;
  assign enable_r = enable_r_q;
  assign fault = fault_q;
  light_timer #(
    .CNT_W(CNT_W),
    .RST_VAL(LONG_T)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(load_val),
    .done(done),
    .start_t(start_t)
  );
endmodule

// File: tb/tb_highway_controller.sv
// tb_highway_controller: vector table, directed corner sequences and random traffic against a phase/age reference model
module tb_highway_controller;
  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;
  localparam int L = 8;
  localparam int Y = 3;
  localparam int R = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic car = 1'b0;
  logic enable_h = 1'b0;
  logic enable_r, start_t, fault;
  logic [2:0] light_h;
  int checks = 0;
  int errors = 0;
  highway_controller #(
    .LONG_CYCLES(L),
    .YELLOW_CYCLES(Y),
    .RED_MAX_CYCLES(R),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .car(car),
    .enable_h(enable_h),
    .enable_r(enable_r),
    .light_h(light_h),
    .start_t(start_t),
    .fault(fault)
  );
  always #5 clk = ~clk;
  typedef struct {
    int ph;
    int age;
    bit f;
    int e;
    bit dq;
  } ms_t;
  ms_t m;
  bit raw [8192];
  function automatic bit rv(input int i);
    return (i >= 1) ? raw[i % 8192] : 1'b0;
  endfunction
  function automatic ms_t nxt(input ms_t s, input bit eh);
    ms_t n = s;
    bit c;
    n.e = s.e + 1;
`ifdef CAR_DEBOUNCE_EN
    c = s.dq;
    n.dq = (rv(n.e - 2) == rv(n.e - 3) && rv(n.e - 3) == rv(n.e - 4)) ? rv(n.e - 2) : s.dq;
`else
    c = rv(n.e - 2);
`endif
    n.age = s.age + 1;
    if (s.ph == 0 && s.age >= L && c) begin
      n.ph = 1;
      n.age = 1;
    end else if (s.ph == 1 && s.age == Y) begin
      n.ph = 2;
      n.age = 1;
    end else if (s.ph == 2 && (eh || s.age == R)) begin
      n.ph = 0;
      n.age = 1;
      n.f = s.f | !eh;
    end
    return n;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) m <= '{0, 0, 1'b0, 0, 1'b0};
    else begin
      raw[(m.e + 1) % 8192] <= car;
      m <= nxt(m, enable_h);
    end
  function automatic logic [2:0] m_light();
    return (m.ph == 0) ? LG : (m.ph == 1) ? LY : LR;
  endfunction
  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask
  task automatic mcheck();
    chk("model light_h", int'(light_h), int'(m_light()));
    chk("model enable_r", int'(enable_r), int'(m.ph == 2 && m.age == 1));
    chk("model start_t", int'(start_t), int'(m.age == 1));
    chk("model fault", int'(fault), int'(m.f));
  endtask
  task automatic step();
    @(negedge clk);
    mcheck();
  endtask
  task automatic do_reset(input bit c);
    reset = 1'b1;
    enable_h = 1'b0;
    car = c;
    @(negedge clk);
    @(negedge clk);
    chk("reset light_h", int'(light_h), int'(LG));
    chk("reset enable_r", int'(enable_r), 0);
    chk("reset start_t", int'(start_t), 0);
    chk("reset fault", int'(fault), 0);
    reset = 1'b0;
  endtask
  task automatic wait_light(input logic [2:0] lt, input int maxc, input string nm);
    int n = 0;
    while (light_h != lt && n < maxc) begin
      step();
      n++;
    end
    chk(nm, int'(light_h), int'(lt));
  endtask
  task automatic wait_enr(input int maxc, input string nm);
    int n = 0;
    while (!enable_r && n < maxc) begin
      step();
      n++;
    end
    chk(nm, int'(enable_r), 1);
  endtask
  task automatic count_run(input logic [2:0] lt, output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (light_h != lt) break;
      n++;
    end
  endtask
  typedef struct {
    bit car;
    bit eh;
    logic [2:0] light;
    bit enr;
    bit st;
    bit flt;
  } vec_t;
  vec_t tbl [1:25];
  initial begin
    int n;
    bit saw;
    for (int k = 1; k <= 8; k++) tbl[k] = '{1'b1, 1'b0, LG, 1'b0, k == 1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, LY, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, LY, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, LY, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, LR, 1'b1, 1'b1, 1'b0};
    for (int k = 13; k <= 15; k++) tbl[k] = '{1'b1, 1'b0, LR, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, LR, 1'b0, 1'b0, 1'b0};
    for (int k = 17; k <= 24; k++) tbl[k] = '{1'b1, 1'b0, LG, 1'b0, k == 17, 1'b0};
    tbl[25] = '{1'b1, 1'b0, LY, 1'b0, 1'b1, 1'b0};
    do_reset(1'b0);
    repeat (100) begin
      step();
      chk("idle light_h", int'(light_h), int'(LG));
      chk("idle enable_r", int'(enable_r), 0);
      chk("idle fault", int'(fault), 0);
    end
    do_reset(1'b1);
    for (int k = 1; k <= 25; k++) begin
      step();
      chk($sformatf("vec%0d light_h", k), int'(light_h), int'(tbl[k].light));
      chk($sformatf("vec%0d enable_r", k), int'(enable_r), int'(tbl[k].enr));
      chk($sformatf("vec%0d start_t", k), int'(start_t), int'(tbl[k].st));
      chk($sformatf("vec%0d fault", k), int'(fault), int'(tbl[k].flt));
      car = tbl[k].car;
      enable_h = tbl[k].eh;
    end
    wait_enr(20, "red entry before red1 handoff");
    enable_h = 1'b1;
    step();
    enable_h = 1'b0;
    chk("red1 handoff light_h", int'(light_h), int'(LG));
    chk("red1 handoff fault", int'(fault), 0);
    count_run(LG, n);
    chk("green length after handoff", n, L);
    wait_enr(20, "red entry before watchdog");
    count_run(LR, n);
    chk("watchdog red length", n, R);
    chk("watchdog light_h", int'(light_h), int'(LG));
    chk("watchdog fault", int'(fault), 1);
    car = 1'b0;
    enable_h = 1'b1;
    step();
    enable_h = 1'b0;
    repeat (20) step();
    chk("fault sticky", int'(fault), 1);
    chk("enable_h ignored in green", int'(light_h), int'(LG));
    car = 1'b1;
    wait_light(LY, 30, "reach yellow");
    step();
    #2 reset = 1'b1;
    #1;
    chk("async reset light_h", int'(light_h), int'(LG));
    chk("async reset enable_r", int'(enable_r), 0);
    chk("async reset fault", int'(fault), 0);
    chk("async reset start_t", int'(start_t), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post-reset start_t", int'(start_t), 1);
    count_run(LG, n);
    chk("post-reset green length", n, L);
    wait_enr(20, "red entry before simultaneous expiry");
    repeat (15) step();
    chk("red cycle 16 light_h", int'(light_h), int'(LR));
    enable_h = 1'b1;
    step();
    enable_h = 1'b0;
    chk("simultaneous expiry light_h", int'(light_h), int'(LG));
    chk("simultaneous expiry fault", int'(fault), 0);
    do_reset(1'b0);
    repeat (12) step();
    car = 1'b1;
    step();
    car = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      step();
      if (light_h == LY) saw = 1'b1;
    end
`ifdef CAR_DEBOUNCE_EN
    chk("one-cycle car pulse yellow", int'(saw), 0);
`else
    chk("one-cycle car pulse yellow", int'(saw), 1);
`endif
    do_reset(1'b0);
    repeat (12) step();
    car = 1'b1;
    repeat (3) step();
    car = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      step();
      if (light_h == LY) saw = 1'b1;
    end
    chk("three-cycle car pulse yellow", int'(saw), 1);
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) car = ~car;
      enable_h = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not finish, got %0d checks", checks);
    $fatal(1);
  end
endmodule
